alarm_annunciator: RTL and testbench

//  Output-side consumer of the alarm controller's 5-bit state code. Registers the code,

---
 rtl/alarm_annunciator_if.sv | 37 +++
 rtl/alarm_annunciator.sv | 242 ++++++++++++++++++++++++
 tb/tb_alarm_annunciator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_annunciator_if.sv
// ---------------------------------------------------------------------------
// alarm_annunciator_if
//   Bundles the signals between the alarm controller, the annunciator and
//   the board outputs. The controller side (master) drives the state code and
//   observes the annunciator outputs. The annunciator side (slave) consumes the
//   state code and drives the LEDs, siren, mode, event counter and fault flag.
//
//   Signals:
//     state       5      alarm controller state code
//     oARMED_LED  1      armed LED (solid / blinking)
//     oZONE_LED   3      latched zone status, bit n = zone n+1
//     oSIREN      1      siren drive
//     oMODE       3      display mode (0 IDLE .. 4 PANIC)
//     oEVENT_CNT  CNT_W  saturating count of entries into TRIGGERED
//     oFAULT      1      sticky illegal-code flag
// ---------------------------------------------------------------------------
interface alarm_annunciator_if #(
  parameter int CNT_W = 8
);
  logic [4:0]       state;
  logic             oARMED_LED;
  logic [2:0]       oZONE_LED;
  logic             oSIREN;
  logic [2:0]       oMODE;
  logic [CNT_W-1:0] oEVENT_CNT;
  logic             oFAULT;

  modport master (
    output state,
    input  oARMED_LED, oZONE_LED, oSIREN, oMODE, oEVENT_CNT, oFAULT
  );

  modport slave (
    input  state,
    output oARMED_LED, oZONE_LED, oSIREN, oMODE, oEVENT_CNT, oFAULT
  );
endinterface

// File: rtl/alarm_annunciator.sv
// ---------------------------------------------------------------------------
// alarm_annunciator
//   Output-side consumer of the alarm controller's 5-bit state code. The code
//   is registered (state_q, with the previous code in prev_q), classified into
//   a display mode, and used to drive the armed LED, zone LEDs, siren, a
//   saturating triggered-event counter and a sticky fault flag. Every output
//   is a register loaded from state_q/prev_q, so an input change shows up on
//   the outputs two clock edges later. One clock tick is 100 ms.
//
//   Parameters:
//     BLINK_HALF  ticks per half-period of the armed-LED blink (PENDING), >=1
//     ALARM_HALF  ticks per half-period of the siren toggle (ALARM), >=1
//     CNT_W       width of the event counter
//
//   Ports:
//     iCLK    in   system clock
//     iRST_n  in   asynchronous active-low reset
//     bus     slave side of alarm_annunciator_if (state in, all outputs)
// ---------------------------------------------------------------------------
module alarm_annunciator #(
  parameter int BLINK_HALF = 5,
  parameter int ALARM_HALF = 3,
  parameter int CNT_W      = 8
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  alarm_annunciator_if.slave  bus
);

  // -------------------------------------------------------------------------
  // Controller state codes
  // -------------------------------------------------------------------------
  localparam logic [4:0] ST_RESET           = 5'h00;
  localparam logic [4:0] ST_ARMED_PENDING   = 5'h02;
  localparam logic [4:0] ST_ARMED           = 5'h03;
  localparam logic [4:0] ST_TRIGGERED       = 5'h04;
  localparam logic [4:0] ST_TRIGGERED_RESET = 5'h05;
  localparam logic [4:0] ST_ZONE_1_ON       = 5'h09;
  localparam logic [4:0] ST_ZONE_2_ON       = 5'h0A;
  localparam logic [4:0] ST_ZONE_3_ON       = 5'h0B;
  localparam logic [4:0] ST_ZONE_1_OFF      = 5'h0C;
  localparam logic [4:0] ST_ZONE_2_OFF      = 5'h0D;
  localparam logic [4:0] ST_ZONE_3_OFF      = 5'h0E;
  localparam logic [4:0] ST_PANIC           = 5'h10;
  localparam logic [4:0] ST_PANIC_RESET     = 5'h11;
  localparam logic [4:0] ST_LAST_LEGAL      = 5'h12;   // UPDATE

  // -------------------------------------------------------------------------
  // Display modes (values are visible on oMODE)
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    MODE_IDLE    = 3'd0,
    MODE_PENDING = 3'd1,
    MODE_ARMED   = 3'd2,
    MODE_ALARM   = 3'd3,
    MODE_PANIC   = 3'd4
  } mode_e;

  // Blink counter sized for the longer of the two half-periods.
  localparam int HALF_MAX = (BLINK_HALF > ALARM_HALF) ? BLINK_HALF : ALARM_HALF;
  localparam int BLINK_W  = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [BLINK_W-1:0] ALARM_LAST = BLINK_W'(ALARM_HALF - 1);

  // -------------------------------------------------------------------------
  // Registers and next-state values
  // -------------------------------------------------------------------------
  logic [4:0]         state_q, prev_q;
  mode_e              mode_q, mode_d, mode_dec;
  logic [BLINK_W-1:0] blink_q, blink_d, blink_last;
  logic               phase_q, phase_d;
  logic               led_q, led_d;
  logic               siren_q, siren_d;
  logic [2:0]         zone_q, zone_d;
  logic [CNT_W-1:0]   evt_q, evt_d;
  logic               fault_q, fault_d;

  // -------------------------------------------------------------------------
  // Input pipeline: current and previous registered state code
  // -------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // the pre-edge value of the others; prev_q must see the old state_q.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= bus.state;
      prev_q  <= state_q;
    end
  end

  // -------------------------------------------------------------------------
  // Mode classification of the registered code. Illegal codes fall into the
  // default arm and therefore decode as IDLE.
  // -------------------------------------------------------------------------
  always_comb begin
    mode_dec = MODE_IDLE;
    case (state_q)
      ST_ARMED_PENDING:                 mode_dec = MODE_PENDING;
      ST_ARMED:                         mode_dec = MODE_ARMED;
      ST_TRIGGERED, ST_TRIGGERED_RESET: mode_dec = MODE_ALARM;
      ST_PANIC, ST_PANIC_RESET:         mode_dec = MODE_PANIC;
      default:                          mode_dec = MODE_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Mode FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      mode_q  <= MODE_IDLE;
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end

  // -------------------------------------------------------------------------
  // Mode FSM: next state, blink counter and phase.
  // A mode change restarts the blink with phase 1 so the LED/siren turns on
  // immediately; the restart takes priority over a wrap in the same cycle.
  // -------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    mode_d     = mode_dec;
    blink_d    = '0;
    phase_d    = phase_q;
    blink_last = (mode_q == MODE_PENDING) ? BLINK_LAST : ALARM_LAST;

    if (mode_d != mode_q) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (mode_q == MODE_PENDING || mode_q == MODE_ALARM) begin
      if (blink_q == blink_last) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BLINK_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // LED / siren decode from the next mode and phase, registered below so the
  // outputs change on the same edge as oMODE.
  // -------------------------------------------------------------------------
  always_comb begin
    led_d   = 1'b0;
    siren_d = 1'b0;
    case (mode_d)
      MODE_PENDING: led_d = phase_d;
      MODE_ARMED:   led_d = 1'b1;
      MODE_ALARM: begin
        led_d   = 1'b1;
        siren_d = phase_d;
      end
      MODE_PANIC: begin
        led_d   = 1'b1;
        siren_d = 1'b1;
      end
      default: begin
        led_d   = 1'b0;
        siren_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Zone latch: ON codes set, OFF codes clear, RESET clears all, every other
  // code (illegal ones included) holds.
  // -------------------------------------------------------------------------
  always_comb begin
    zone_d = zone_q;
    case (state_q)
      ST_ZONE_1_ON:  zone_d[0] = 1'b1;
      ST_ZONE_2_ON:  zone_d[1] = 1'b1;
      ST_ZONE_3_ON:  zone_d[2] = 1'b1;
      ST_ZONE_1_OFF: zone_d[0] = 1'b0;
      ST_ZONE_2_OFF: zone_d[1] = 1'b0;
      ST_ZONE_3_OFF: zone_d[2] = 1'b0;
      ST_RESET:      zone_d    = '0;
      default:       zone_d    = zone_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Event counter: one count per entry into TRIGGERED (rising edge of the
  // "state is TRIGGERED" condition), saturating at all-ones.
  // -------------------------------------------------------------------------
  always_comb begin
    evt_d = evt_q;
    if (state_q == ST_TRIGGERED && prev_q != ST_TRIGGERED && evt_q != '1) begin
      evt_d = evt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Fault flag: sticky on any code above the legal range, cleared by RESET.
  // -------------------------------------------------------------------------
  always_comb begin
    fault_d = fault_q;
    if (state_q > ST_LAST_LEGAL) begin
      fault_d = 1'b1;
    end else if (state_q == ST_RESET) begin
      fault_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      led_q   <= 1'b0;
      siren_q <= 1'b0;
      zone_q  <= '0;
      evt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      led_q   <= led_d;
      siren_q <= siren_d;
      zone_q  <= zone_d;
      evt_q   <= evt_d;
      fault_q <= fault_d;
    end
  end

  assign bus.oARMED_LED = led_q;
  assign bus.oZONE_LED  = zone_q;
  assign bus.oSIREN     = siren_q;
  assign bus.oMODE      = mode_q;
  assign bus.oEVENT_CNT = evt_q;
  assign bus.oFAULT     = fault_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// ---------------------------------------------------------------------------
// tb_alarm_annunciator
//   Drives the annunciator with directed sequences and randomized state codes.
//   A behavioural model tracks what every output must be; a compare process
//   checks all outputs against it on each falling clock edge. Directed
//   sequences additionally check hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_alarm_annunciator;

  localparam int BLINK_HALF = 5;
  localparam int ALARM_HALF = 3;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic iCLK = 1'b0;
  logic iRST_n;

  always #5 iCLK = ~iCLK;

  alarm_annunciator_if #(.CNT_W(CNT_W)) bus ();

  alarm_annunciator #(
    .BLINK_HALF (BLINK_HALF),
    .ALARM_HALF (ALARM_HALF),
    .CNT_W      (CNT_W)
  ) dut (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .bus    (bus)
  );

  // -------------------------------------------------------------------------
  // Comparison bookkeeping
  // -------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model.
  // Outputs after an edge are a function of the code seen one edge earlier
  // (sq) and the one before (pq). Blink phase is derived from how many edges
  // the mode has been unchanged: phase = 1 for the first HALF edges, then
  // alternates every HALF edges.
  // -------------------------------------------------------------------------
  logic [4:0] m_sq, m_pq;
  int         m_mode, m_run, m_cnt, m_half, m_new;
  bit  [2:0]  m_zone;
  bit         m_fault, m_led, m_siren, m_phase;

  function automatic int mode_of(input logic [4:0] c);
    if (c == 5'h02)                 return 1;
    if (c == 5'h03)                 return 2;
    if (c == 5'h04 || c == 5'h05)   return 3;
    if (c == 5'h10 || c == 5'h11)   return 4;
    return 0;
  endfunction

  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      m_sq = '0; m_pq = '0; m_mode = 0; m_run = 0; m_cnt = 0;
      m_zone = '0; m_fault = 0; m_led = 0; m_siren = 0;
    end else begin
      m_new   = mode_of(m_sq);
      m_run   = (m_new == m_mode) ? m_run + 1 : 0;
      m_mode  = m_new;
      m_half  = (m_new == 1) ? BLINK_HALF : ALARM_HALF;
      m_phase = ((m_run / m_half) % 2) == 0;
      m_led   = (m_new == 1) ? m_phase : (m_new >= 2);
      m_siren = (m_new == 3) ? m_phase : (m_new == 4);
      if (m_sq >= 5'h09 && m_sq <= 5'h0B)      m_zone[m_sq - 9]  = 1'b1;
      else if (m_sq >= 5'h0C && m_sq <= 5'h0E) m_zone[m_sq - 12] = 1'b0;
      else if (m_sq == 5'h00)                  m_zone = '0;
      if (m_sq == 5'h04 && m_pq != 5'h04 && m_cnt < CNT_MAX) m_cnt++;
      if (m_sq > 5'h12)       m_fault = 1'b1;
      else if (m_sq == 5'h00) m_fault = 1'b0;
      m_pq = m_sq;
      m_sq = bus.state;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge iCLK) begin
    if (cmp_en) begin
      check("mode",  32'(bus.oMODE),      32'(m_mode));
      check("led",   32'(bus.oARMED_LED), 32'(m_led));
      check("siren", 32'(bus.oSIREN),     32'(m_siren));
      check("zone",  32'(bus.oZONE_LED),  32'(m_zone));
      check("evt",   32'(bus.oEVENT_CNT), 32'(m_cnt));
      check("fault", 32'(bus.oFAULT),     32'(m_fault));
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge; return one edge later)
  // -------------------------------------------------------------------------
  task automatic drive(input logic [4:0] s);
    bus.state = s;
    @(negedge iCLK);
  endtask

  task automatic pulse_reset();
    iRST_n = 1'b0;
    @(negedge iCLK);
    iRST_n = 1'b1;
  endtask

  int          exp_sir [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
  logic [4:0]  seq4    [9] = '{5'h03, 5'h03, 5'h04, 5'h05, 5'h04, 5'h03, 5'h03, 5'h03, 5'h03};

  initial begin
    logic [4:0] code;
    int         hold, r;

    bus.state = 5'h01;
    iRST_n    = 1'b1;
    #1 iRST_n = 1'b0;
    cmp_en    = 1'b1;
    repeat (3) @(negedge iCLK);

    // 1: reset state with DISARMED held
    check("rst_mode",  32'(bus.oMODE), 0);
    check("rst_led",   32'(bus.oARMED_LED), 0);
    check("rst_evt",   32'(bus.oEVENT_CNT), 0);
    iRST_n = 1'b1;
    repeat (3) drive(5'h01);
    check("t1_mode",  32'(bus.oMODE), 0);
    check("t1_siren", 32'(bus.oSIREN), 0);
    check("t1_fault", 32'(bus.oFAULT), 0);
    check("t1_zone",  32'(bus.oZONE_LED), 0);

    // 2: PENDING blink, edge e counted from the first edge that samples 02
    for (int e = 1; e <= 12; e++) begin
      drive(5'h02);
      if (e >= 2) check("t2_led", 32'(bus.oARMED_LED), (e <= 6 || e >= 12) ? 1 : 0);
      if (e == 2) check("t2_mode", 32'(bus.oMODE), 1);
    end

    // 3: zone scan
    drive(5'h01); drive(5'h01);
    drive(5'h09); drive(5'h0D); drive(5'h0B); drive(5'h01);
    check("t3_zone_101", 32'(bus.oZONE_LED), 32'b101);
    drive(5'h0C); drive(5'h01);
    check("t3_zone_100", 32'(bus.oZONE_LED), 32'b100);
    drive(5'h00); drive(5'h01);
    check("t3_zone_000", 32'(bus.oZONE_LED), 32'b000);

    // 4: alarm siren pattern and event counting
    bus.state = 5'h01;
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      drive(seq4[i]);
      check("t4_siren", 32'(bus.oSIREN), 32'(exp_sir[i]));
    end
    check("t4_evt2", 32'(bus.oEVENT_CNT), 2);
    repeat (300) begin
      drive(5'h04);
      drive(5'h03);
    end
    drive(5'h03); drive(5'h03);
    check("t4_evt_sat", 32'(bus.oEVENT_CNT), 255);

    // 5: panic
    drive(5'h10); drive(5'h10);
    check("t5_mode",   32'(bus.oMODE), 4);
    check("t5_siren",  32'(bus.oSIREN), 1);
    drive(5'h11); drive(5'h11);
    check("t5_siren2", 32'(bus.oSIREN), 1);
    drive(5'h03); drive(5'h03);
    check("t5_siren0", 32'(bus.oSIREN), 0);
    check("t5_armed",  32'(bus.oMODE), 2);

    // 6: illegal code
    drive(5'h09); drive(5'h01);
    drive(5'h1A); drive(5'h1A);
    check("t6_fault",  32'(bus.oFAULT), 1);
    check("t6_mode",   32'(bus.oMODE), 0);
    check("t6_zone",   32'(bus.oZONE_LED), 32'b001);
    check("t6_evt",    32'(bus.oEVENT_CNT), 255);
    drive(5'h01); drive(5'h01);
    check("t6_sticky", 32'(bus.oFAULT), 1);
    drive(5'h00); drive(5'h01);
    check("t6_clear",  32'(bus.oFAULT), 0);

    // 6b: asynchronous reset in the middle of ALARM
    drive(5'h03); drive(5'h04); drive(5'h04); drive(5'h04);
    check("t6b_alarm", 32'(bus.oMODE), 3);
    #2 iRST_n = 1'b0;
    #1;
    check("t6b_mode",  32'(bus.oMODE), 0);
    check("t6b_led",   32'(bus.oARMED_LED), 0);
    check("t6b_siren", 32'(bus.oSIREN), 0);
    check("t6b_evt",   32'(bus.oEVENT_CNT), 0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    drive(5'h04); drive(5'h04);
    check("t6b_resume", 32'(bus.oMODE), 3);

    // Randomized code sequences with hold times long enough to blink
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       code = 5'($urandom_range(19, 31));
      else if (r < 12) code = 5'h00;
      else if (r < 45) begin
        case ($urandom_range(0, 4))
          0:       code = 5'h02;
          1:       code = 5'h03;
          2:       code = 5'h04;
          3:       code = 5'h05;
          default: code = 5'h10;
        endcase
      end else     code = 5'($urandom_range(1, 18));
      hold = $urandom_range(1, 14);
      if ($urandom_range(0, 99) == 0) begin
        #2 iRST_n = 1'b0;
        @(negedge iCLK);
        iRST_n = 1'b1;
      end
      repeat (hold) drive(code);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
